// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache/memory arbiter, the caches and the memory model.
package mem_arb_pkg;

  // Default widths reused by the caches and the memory model.
  localparam int MEM_ADDR_W  = 28;   // block address (word address without 2-bit offset)
  localparam int MEM_DATA_W  = 128;  // one cache block
  localparam int GRANT_CNT_W = 16;   // performance-debug grant counters

  // Arbiter states; encodings are fixed so debug dumps read the same everywhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  // Encoding of the "last served" bit fed to the round-robin chooser.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: a lone requester always wins; on a tie the
// requester that was not served last wins. Bit 0 is the I-cache, bit 1 the D-cache.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // Pick the winner; a tie is broken against whoever was served last.
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = (last == LAST_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-memory port between the I-cache and the D-cache. A grant is
// held for a whole transaction and always returns through IDLE, so the other
// cache can interleave between back-to-back requests of one cache.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int CNT_W  = GRANT_CNT_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  // I-cache side
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // D-cache side
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // Memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // Debug
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic [1:0]       req;
  logic [1:0]       win;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A cache requests whenever it asserts read or write.
  assign req = {d_mem_read | d_mem_write, i_mem_read | i_mem_write};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  // Next state: arbitrate in IDLE, leave a grant on completion or abandonment.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    last_d  = last_q;
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    case (state_q)
      IDLE: begin
        if (win[1]) begin
          state_d = GNT_D;
          last_d  = LAST_D;
          d_cnt_d = (d_cnt_q == CNT_MAX) ? d_cnt_q : d_cnt_q + CNT_W'(1);
        end else if (win[0]) begin
          state_d = GNT_I;
          last_d  = LAST_I;
          i_cnt_d = (i_cnt_q == CNT_MAX) ? i_cnt_q : i_cnt_q + CNT_W'(1);
        end
      end
      GNT_I: if (mem_ready || !req[0]) state_d = IDLE;
      GNT_D: if (mem_ready || !req[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, last-served and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (proc_reset) begin
      state_q <= IDLE;
      last_q  <= LAST_I;
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  // Pass the owner's request through to memory and route ready back to it only.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    grant       = 2'b00;
    if (!proc_reset) begin
      case (state_q)
        GNT_I: begin
          // Read together with write is illegal; the write is the one forwarded.
          mem_write   = i_mem_write;
          mem_read    = i_mem_read & ~i_mem_write;
          mem_addr    = i_mem_addr;
          mem_wdata   = i_mem_wdata;
          i_mem_ready = mem_ready;
          grant       = 2'b01;
        end
        GNT_D: begin
          mem_write   = d_mem_write;
          mem_read    = d_mem_read & ~d_mem_write;
          mem_addr    = d_mem_addr;
          mem_wdata   = d_mem_wdata;
          d_mem_ready = mem_ready;
          grant       = 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Read data is broadcast; each cache qualifies it with its own ready.
  assign i_mem_rdata = proc_reset ? '0 : mem_rdata;
  assign d_mem_rdata = proc_reset ? '0 : mem_rdata;

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

  // A cache never drives read and write together.
  a_i_rw_exclusive: assert property (@(posedge clk) disable iff (proc_reset)
    !(i_mem_read && i_mem_write));
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (proc_reset)
    !(d_mem_read && d_mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two cache drivers, a latency-programmable
// memory model and a grant-order scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = MEM_ADDR_W;
  localparam int DW = MEM_DATA_W;
  localparam int CW = 4;

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [127:0] wdata;
    int          abandon;   // 0: wait for ready, N: drop request after N cycles
  } cmd_t;

  typedef struct {
    logic [1:0]   grant;
    logic [27:0]  addr;
    bit           wr;
    logic [127:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          proc_reset;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata, mem_wdata;
  logic [DW-1:0] i_mem_rdata, d_mem_rdata, mem_rdata;
  logic          i_mem_ready, d_mem_ready, mem_ready;
  logic          mem_read, mem_write;
  logic [1:0]    grant;
  logic [CW-1:0] i_grant_cnt, d_grant_cnt;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wdata (i_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ready (i_mem_ready),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_rdata (d_mem_rdata),
    .d_mem_ready (d_mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .grant       (grant),
    .i_grant_cnt (i_grant_cnt),
    .d_grant_cnt (d_grant_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_pattern(input logic [27:0] a);
    return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
  endfunction

  // ---------------- scoreboard and expected counters ----------------
  exp_t sb_q[$];
  cmd_t i_cmd_q[$];
  cmd_t d_cmd_q[$];
  int   exp_i_cnt = 0;
  int   exp_d_cnt = 0;
  int   rdy_cnt_i = 0;
  int   rdy_cnt_d = 0;

  task automatic issue(input bit is_d, input bit wr, input logic [27:0] a,
                       input logic [127:0] wd, input int abandon);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.abandon = abandon;
    if (is_d) d_cmd_q.push_back(c);
    else      i_cmd_q.push_back(c);
  endtask

  // Expected grant order is pushed here; each grant bumps a saturating count.
  task automatic sb_push(input bit is_d, input bit wr, input logic [27:0] a,
                         input logic [127:0] wd);
    exp_t e;
    e.grant = is_d ? 2'b10 : 2'b01;
    e.addr = a; e.wr = wr; e.wdata = wd;
    sb_q.push_back(e);
    if (is_d) exp_d_cnt = (exp_d_cnt == 15) ? 15 : exp_d_cnt + 1;
    else      exp_i_cnt = (exp_i_cnt == 15) ? 15 : exp_i_cnt + 1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_i_grant_cnt"}, i_grant_cnt, exp_i_cnt[CW-1:0]);
    check({tag, "_d_grant_cnt"}, d_grant_cnt, exp_d_cnt[CW-1:0]);
  endtask

  // ---------------- cache drivers (g=0: I-cache, g=1: D-cache) ----------------
  for (genvar g = 0; g < 2; g++) begin : g_cache
    logic          rd;
    logic          wr;
    logic [27:0]   addr;
    logic [127:0]  wdata;
    initial begin
      cmd_t c;
      int   waited;
      bit   active, done, abort_req;
      rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      active = 0; done = 0; abort_req = 0; waited = 0;
      c.wr = 0; c.addr = '0; c.wdata = '0; c.abandon = 0;
      forever begin
        @(posedge clk); #1;
        if (done || abort_req) begin
          rd = 1'b0; wr = 1'b0; active = 0; done = 0; abort_req = 0;
        end else if (active && c.abandon > 0 && waited >= c.abandon) begin
          rd = 1'b0; wr = 1'b0; active = 0;
        end
        if (!active && !proc_reset &&
            ((g == 0) ? (i_cmd_q.size() != 0) : (d_cmd_q.size() != 0))) begin
          c = (g == 0) ? i_cmd_q.pop_front() : d_cmd_q.pop_front();
          rd = !c.wr; wr = c.wr; addr = c.addr; wdata = c.wdata;
          active = 1; waited = 0;
        end
        @(negedge clk);
        if (active) begin
          waited++;
          if (proc_reset) abort_req = 1;
          else if ((g == 0) ? i_mem_ready : d_mem_ready) done = 1;
          else if (waited > 300) begin
            check($sformatf("cache%0d_timeout", g), 128'd0, 128'd1);
            abort_req = 1;
          end
        end
      end
    end
  end

  assign i_mem_read  = g_cache[0].rd;
  assign i_mem_write = g_cache[0].wr;
  assign i_mem_addr  = g_cache[0].addr;
  assign i_mem_wdata = g_cache[0].wdata;
  assign d_mem_read  = g_cache[1].rd;
  assign d_mem_write = g_cache[1].wr;
  assign d_mem_addr  = g_cache[1].addr;
  assign d_mem_wdata = g_cache[1].wdata;

  // ---------------- memory model ----------------
  int   mem_lat = 4;
  int   busy;
  logic model_ready;
  logic late_ready;

  always @(posedge clk) begin
    if (proc_reset) begin
      model_ready <= 1'b0;
      busy        <= 0;
      mem_rdata   <= {4{32'hCAFE_F00D}};
    end else begin
      model_ready <= 1'b0;
      if (model_ready) begin
        busy <= 0;
      end else if (mem_read || mem_write) begin
        if (busy >= mem_lat - 1) begin
          model_ready <= 1'b1;
          mem_rdata   <= mem_pattern(mem_addr);
          busy        <= 0;
        end else begin
          busy <= busy + 1;
        end
      end else begin
        busy <= 0;
      end
    end
  end

  assign mem_ready = model_ready | late_ready;

  // ---------------- monitor: grant order, ready routing, read data ----------------
  initial begin : monitor
    logic [1:0]  prev;
    logic [27:0] cur_addr;
    exp_t        e;
    prev = 2'b00;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      if (!proc_reset) begin
        if (prev != 2'b00 && grant != 2'b00 && grant != prev)
          check("no_direct_handoff", grant, 2'b00);
        if (prev == 2'b00 && grant != 2'b00) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_grant", grant, 2'b00);
          end else begin
            e = sb_q.pop_front();
            check("sb_grant", grant, e.grant);
            check("sb_addr", mem_addr, e.addr);
            check("sb_write", mem_write, e.wr);
            check("sb_read", mem_read, !e.wr);
            if (e.wr) check("sb_wdata", mem_wdata, e.wdata);
          end
          cur_addr = mem_addr;
        end
        if (i_mem_ready || d_mem_ready) begin
          check("ready_owner", {d_mem_ready, i_mem_ready}, grant);
          check("rdata", d_mem_ready ? d_mem_rdata : i_mem_rdata, mem_pattern(cur_addr));
          if (i_mem_ready) rdy_cnt_i++;
          if (d_mem_ready) rdy_cnt_d++;
        end
      end
      prev = proc_reset ? 2'b00 : grant;
    end
  end

  // ---------------- helpers ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    proc_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_i_rdata", i_mem_rdata, '0);
    check("rst_d_rdata", d_mem_rdata, '0);
    check("rst_i_ready", i_mem_ready, 1'b0);
    check("rst_d_ready", d_mem_ready, 1'b0);
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    check_counts("rst");
    @(posedge clk); #1;
    proc_reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int k = 0; k < 2000 && quiet < 3; k++) begin
      @(negedge clk);
      if (i_cmd_q.size() == 0 && d_cmd_q.size() == 0 && !i_mem_read && !i_mem_write &&
          !d_mem_read && !d_mem_write && grant == 2'b00) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle_reached"}, (quiet >= 3), 1'b1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g_exp);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant != g_exp && k < 100);
    check({tag, "_grant_seen"}, grant, g_exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap_i, snap_d;
    proc_reset = 1'b1;
    late_ready = 1'b0;
    apply_reset();

    // 1: single D read, grant one cycle after the request, one ready pulse.
    @(negedge clk);
    issue(1, 0, 28'h0000010, '0, 0);
    sb_push(1, 0, 28'h0000010, '0);
    @(negedge clk);
    check("t1_grant_before", grant, 2'b00);
    @(negedge clk);
    check("t1_grant", grant, 2'b10);
    check("t1_mem_read", mem_read, 1'b1);
    check("t1_mem_addr", mem_addr, 28'h0000010);
    wait_idle("t1");
    check("t1_d_pulses", rdy_cnt_d, 1);
    check("t1_i_pulses", rdy_cnt_i, 0);
    check("t1_d_cnt_one", d_grant_cnt, 4'd1);
    check_counts("t1");

    // 2: simultaneous requests after reset: D first, then I; repeated tie: D again.
    apply_reset();
    @(negedge clk);
    issue(0, 0, 28'h0000020, '0, 0);
    issue(1, 0, 28'h0000030, '0, 0);
    sb_push(1, 0, 28'h0000030, '0);
    sb_push(0, 0, 28'h0000020, '0);
    wait_idle("t2a");
    @(negedge clk);
    issue(0, 0, 28'h0000021, '0, 0);
    issue(1, 0, 28'h0000031, '0, 0);
    sb_push(1, 0, 28'h0000031, '0);
    sb_push(0, 0, 28'h0000021, '0);
    wait_idle("t2b");
    check_counts("t2");

    // 3: D write-back then D read; the waiting I request interleaves.
    snap_d = rdy_cnt_d;
    @(negedge clk);
    issue(1, 1, 28'h00000A0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 0);
    sb_push(1, 1, 28'h00000A0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
    wait_grant("t3_wb", 2'b10);
    issue(0, 0, 28'h0000200, '0, 0);
    issue(1, 0, 28'h00000A0, '0, 0);
    sb_push(0, 0, 28'h0000200, '0);
    sb_push(1, 0, 28'h00000A0, '0);
    wait_idle("t3");
    check("t3_d_pulses", rdy_cnt_d - snap_d, 2);
    check_counts("t3");

    // 4: reset in the middle of a D transaction, then a stray late ready.
    mem_lat = 1000;
    snap_i = rdy_cnt_i;
    snap_d = rdy_cnt_d;
    @(negedge clk);
    issue(1, 0, 28'h0000300, '0, 0);
    sb_push(1, 0, 28'h0000300, '0);
    wait_grant("t4", 2'b10);
    @(posedge clk); #1;
    proc_reset = 1'b1;
    @(negedge clk);
    check("t4_rst_grant", grant, 2'b00);
    check("t4_rst_mem_read", mem_read, 1'b0);
    check("t4_rst_d_ready", d_mem_ready, 1'b0);
    check("t4_rst_d_rdata", d_mem_rdata, '0);
    @(negedge clk);
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    check_counts("t4_rst");
    @(posedge clk); #1;
    proc_reset = 1'b0;
    mem_lat = 4;
    late_ready = 1'b1;
    @(negedge clk);
    check("t4_late_i_ready", i_mem_ready, 1'b0);
    check("t4_late_d_ready", d_mem_ready, 1'b0);
    check("t4_late_grant", grant, 2'b00);
    check("t4_late_mem_read", mem_read, 1'b0);
    @(posedge clk); #1;
    late_ready = 1'b0;
    wait_idle("t4");
    check("t4_no_i_pulse", rdy_cnt_i - snap_i, 0);
    check("t4_no_d_pulse", rdy_cnt_d - snap_d, 0);

    // 6: D abandons its request; the pending I request is granted after one IDLE cycle.
    mem_lat = 1000;
    @(negedge clk);
    issue(1, 0, 28'h0000400, '0, 3);
    sb_push(1, 0, 28'h0000400, '0);
    wait_grant("t6", 2'b10);
    issue(0, 0, 28'h0000500, '0, 0);
    sb_push(0, 0, 28'h0000500, '0);
    for (int k = 0; k < 20 && d_mem_read; k++) @(negedge clk);
    check("t6_d_dropped", d_mem_read, 1'b0);
    check("t6_still_d", grant, 2'b10);
    check("t6_mem_read_off", mem_read, 1'b0);
    mem_lat = 4;
    @(negedge clk);
    check("t6_idle", grant, 2'b00);
    @(negedge clk);
    check("t6_i_grant", grant, 2'b01);
    wait_idle("t6");
    check_counts("t6");

    // 5: twenty I-only transactions saturate the 4-bit counter.
    mem_lat = 1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      issue(0, 0, 28'h0000600 + 28'(k), '0, 0);
      sb_push(0, 0, 28'h0000600 + 28'(k), '0);
    end
    wait_idle("t5");
    check("t5_i_saturated", i_grant_cnt, 4'hF);
    check_counts("t5");

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
